// File: rtl/mips_data_memory_pkg.sv
// mips_data_memory_pkg
// Shared constants and helpers for the MIPS data memory and its TX FIFO.
//   - MMIO window base (a[31:16]) and the register offsets inside it
//   - RAM geometry (256 words) and TX FIFO geometry (4 entries)
//   - STATUS register bit layout and a packing helper
// The MMIO features that use these constants exist only when the
// DMEM_MMIO_EN macro is defined.
package mips_data_memory_pkg;

  localparam int DATA_W = 32;

  // MMIO window: any address whose upper half equals MMIO_BASE
  localparam logic [15:0] MMIO_BASE   = 16'hFFFF;
  localparam logic [15:0] TX_DATA_OFS = 16'h0000;
  localparam logic [15:0] STATUS_OFS  = 16'h0004;
  localparam logic [15:0] CYCLES_OFS  = 16'h0008;

  // RAM geometry: word-addressed by a[9:2]
  localparam int RAM_DEPTH = 256;
  localparam int RAM_AW    = 8;

  // TX FIFO geometry
  localparam int FIFO_DEPTH = 4;
  localparam int FIFO_PW    = 2;  // pointer width
  localparam int FIFO_CW    = 3;  // count width, holds 0..FIFO_DEPTH

  // STATUS layout: {26'b0, overflow, full, empty, count[2:0]}
  localparam int STATUS_COUNT_LSB    = 0;
  localparam int STATUS_EMPTY_BIT    = 3;
  localparam int STATUS_FULL_BIT     = 4;
  localparam int STATUS_OVERFLOW_BIT = 5;

  typedef enum logic [1:0] {
    MMIO_TX_DATA,
    MMIO_STATUS,
    MMIO_CYCLES,
    MMIO_NONE
  } mmio_reg_e;

  // Map the low half of an MMIO address to the register it selects.
  function automatic mmio_reg_e mmio_decode(input logic [15:0] ofs);
    case (ofs)
      TX_DATA_OFS: return MMIO_TX_DATA;
      STATUS_OFS:  return MMIO_STATUS;
      CYCLES_OFS:  return MMIO_CYCLES;
      default:     return MMIO_NONE;
    endcase
  endfunction

  // Assemble the STATUS read word from the FIFO flags.
  function automatic logic [DATA_W-1:0] status_word(
    input logic               overflow,
    input logic               full,
    input logic               empty,
    input logic [FIFO_CW-1:0] count
  );
    logic [DATA_W-1:0] w;
    w = '0;
    w[STATUS_OVERFLOW_BIT]            = overflow;
    w[STATUS_FULL_BIT]                = full;
    w[STATUS_EMPTY_BIT]               = empty;
    w[STATUS_COUNT_LSB +: FIFO_CW]    = count;
    return w;
  endfunction

endpackage

// File: rtl/mips_data_memory_tx_fifo.sv
// mips_tx_fifo
// Four-entry transmit FIFO behind the TX_DATA MMIO register.
// Ports:
//   clk, reset    clock and asynchronous active-high reset
//   push, wdata   enqueue request and word; ignored while full
//   pop           dequeue request; ignored while empty
//   full, empty   occupancy flags
//   count         number of queued words, 0..4
//   head          word at the read pointer, 0 while empty
// A push while full is dropped even when a pop happens on the same edge;
// the caller detects that case from push & full.
module mips_tx_fifo
  import mips_data_memory_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic [DATA_W-1:0]  wdata,
  input  logic               pop,
  output logic               full,
  output logic               empty,
  output logic [FIFO_CW-1:0] count,
  output logic [DATA_W-1:0]  head
);

  logic [DATA_W-1:0]  entries_reg [FIFO_DEPTH];
  logic [FIFO_PW-1:0] wptr_reg;
  logic [FIFO_PW-1:0] rptr_reg;
  logic [FIFO_CW-1:0] count_reg;
  logic [FIFO_CW-1:0] count_next;
  logic               push_ok;
  logic               pop_ok;
  logic [FIFO_DEPTH-1:0] entry_we;

  assign full    = (count_reg == FIFO_CW'(FIFO_DEPTH));
  assign empty   = (count_reg == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  // One write strobe per storage slot, selected by the write pointer.
  genvar gi;
  generate
    for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry_we
      assign entry_we[gi] = push_ok && (wptr_reg == FIFO_PW'(gi));
    end
  endgenerate

  // Storage is not reset: stale words are never visible because head is
  // masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (entry_we[i]) begin
        entries_reg[i] <= wdata;
      end
    end
  end

  always_comb begin
    count_next = count_reg;
    case ({push_ok, pop_ok})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  // Pointers wrap naturally at 3 -> 0 through their 2-bit width.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_reg  <= '0;
      rptr_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (push_ok) wptr_reg <= wptr_reg + 1'b1;
      if (pop_ok)  rptr_reg <= rptr_reg + 1'b1;
      count_reg <= count_next;
    end
  end

  assign count = count_reg;
  assign head  = empty ? '0 : entries_reg[rptr_reg];

endmodule

// File: rtl/mips_data_memory.sv
// mips_data_memory
// Data-side memory for a single-cycle MIPS core: 256x32 RAM with a
// combinational read port, plus (with DMEM_MMIO_EN defined) a small MMIO
// window at 0xFFFF_xxxx holding a TX FIFO and a free-running cycle counter.
// Ports:
//   clk         single clock, state updates on the rising edge
//   reset       asynchronous active-high reset (RAM contents are kept)
//   a, we, wd   CPU byte address, write enable, write data
//   rd          combinational read data for address a
//   out_valid   TX FIFO holds at least one word
//   out_data    TX FIFO head word (0 while empty)
//   out_ready   consumer takes the head word on the next rising edge
// Configuration macro: DMEM_MMIO_EN. Without it every address maps to RAM
// through a[9:2], the TX stream outputs are tied to 0 and out_ready is
// ignored.
module mips_data_memory
  import mips_data_memory_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] a,
  input  logic              we,
  input  logic [DATA_W-1:0] wd,
  output logic [DATA_W-1:0] rd,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready
);

  // ------------------------------------------------------------------
  // RAM: word index a[9:2]; everything above bit 9 aliases.
  // ------------------------------------------------------------------
  logic [DATA_W-1:0] ram [RAM_DEPTH];
  logic [RAM_AW-1:0] ram_idx;
  logic              ram_we;
  logic [DATA_W-1:0] ram_rd;

  assign ram_idx = a[RAM_AW+1:2];
  assign ram_rd  = ram[ram_idx];

  // No reset term: a write that lands while reset is high still updates RAM.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram[ram_idx] <= wd;
    end
  end

`ifdef DMEM_MMIO_EN
  // ------------------------------------------------------------------
  // MMIO decode, TX FIFO, STATUS overflow flag and CYCLES counter
  // ------------------------------------------------------------------
  logic               mmio_sel;
  mmio_reg_e          mmio_reg;
  logic               tx_push;
  logic               status_wr;
  logic               fifo_full;
  logic               fifo_empty;
  logic [FIFO_CW-1:0] fifo_count;
  logic [DATA_W-1:0]  fifo_head;
  logic               overflow_reg;
  logic [DATA_W-1:0]  cycles_reg;
  logic [DATA_W-1:0]  mmio_rd;

  assign mmio_sel  = (a[31:16] == MMIO_BASE);
  assign mmio_reg  = mmio_decode(a[15:0]);
  assign ram_we    = we & ~mmio_sel;
  assign tx_push   = we & mmio_sel & (mmio_reg == MMIO_TX_DATA);
  assign status_wr = we & mmio_sel & (mmio_reg == MMIO_STATUS);

  // The FIFO gates pop with its own empty flag, so out_ready can be passed
  // straight through.
  mips_tx_fifo u_tx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (tx_push),
    .wdata (wd),
    .pop   (out_ready),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count),
    .head  (fifo_head)
  );

  // Sticky overflow: set by a push that finds the FIFO full (the word is
  // dropped even if a pop frees a slot on the same edge), cleared by any
  // write to STATUS.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_reg <= 1'b0;
    end else if (tx_push && fifo_full) begin
      overflow_reg <= 1'b1;
    end else if (status_wr) begin
      overflow_reg <= 1'b0;
    end
  end

  // Free-running cycle counter; wraps 0xFFFFFFFF -> 0 by width.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycles_reg <= '0;
    end else begin
      cycles_reg <= cycles_reg + 1'b1;
    end
  end

  always_comb begin
    mmio_rd = '0;
    case (mmio_reg)
      MMIO_STATUS: mmio_rd = status_word(overflow_reg, fifo_full, fifo_empty, fifo_count);
      MMIO_CYCLES: mmio_rd = cycles_reg;
      default:     mmio_rd = '0;  // TX_DATA and unmapped offsets read 0
    endcase
  end

  assign rd        = mmio_sel ? mmio_rd : ram_rd;
  assign out_valid = ~fifo_empty;
  assign out_data  = fifo_head;

`else
  // ------------------------------------------------------------------
  // RAM only: every address reaches RAM, TX stream is idle.
  // ------------------------------------------------------------------
  logic unused_inputs;

  assign ram_we        = we;
  assign rd            = ram_rd;
  assign out_valid     = 1'b0;
  assign out_data      = '0;
  assign unused_inputs = &{1'b0, reset, out_ready, a[31:RAM_AW+2], a[1:0]};
`endif

endmodule

// File: tb/tb_mips_data_memory.sv
module tb_mips_data_memory;

  localparam logic [31:0] TX_ADDR  = 32'hFFFF_0000;
  localparam logic [31:0] ST_ADDR  = 32'hFFFF_0004;
  localparam logic [31:0] CYC_ADDR = 32'hFFFF_0008;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] a;
  logic        we;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready;

  int total = 0;
  int bad   = 0;

  // Expected TX words, pushed when an accepted push is driven and popped
  // when the DUT presents a word that will be taken on the next edge.
  logic [31:0] sb [$];

  typedef struct {
    logic        w;
    logic [31:0] addr;
    logic [31:0] data;
    logic        chk;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [$];

  mips_data_memory dut (
    .clk       (clk),
    .reset     (reset),
    .a         (a),
    .we        (we),
    .wd        (wd),
    .rd        (rd),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  // Drive one bus cycle after the falling edge, then compare any word the
  // consumer is about to take against the scoreboard.
  task automatic step(input logic w, input logic [31:0] addr, input logic [31:0] data,
                      input logic rdy);
    @(negedge clk);
    we = w; a = addr; wd = data; out_ready = rdy;
    #1;
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_pop: got %h want no word", out_data);
      end else begin
        check("fifo_head", out_data, sb.pop_front());
      end
    end
  endtask

  initial begin
    reset = 1'b1; we = 1'b0; a = '0; wd = '0; out_ready = 1'b0;
    #1;
    check("rst_out_valid", {31'b0, out_valid}, 32'h0);
    check("rst_out_data", out_data, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Ten rising edges after release: the tenth step reads CYCLES.
    repeat (9) step(1'b0, 32'h0, 32'h0, 1'b0);
`ifdef DMEM_MMIO_EN
    step(1'b0, CYC_ADDR, 32'h0, 1'b0);
    check("cycles_after_10", rd, 32'd10);
    step(1'b0, ST_ADDR, 32'h0, 1'b0);
    check("status_after_reset", rd, 32'h08);
`else
    step(1'b0, 32'h0, 32'h0, 1'b0);
`endif

    // ---------------- RAM vectors ----------------
    vecs.push_back('{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 32'h0000_0010, 32'h0,         1'b1, 32'hDEAD_BEEF});
    vecs.push_back('{1'b0, 32'h0000_0410, 32'h0,         1'b1, 32'hDEAD_BEEF});
    vecs.push_back('{1'b0, 32'h0000_0013, 32'h0,         1'b1, 32'hDEAD_BEEF});
    vecs.push_back('{1'b1, 32'h0000_0020, 32'h1234_5678, 1'b0, 32'h0});
    vecs.push_back('{1'b1, 32'h0000_0020, 32'hCAFE_F00D, 1'b1, 32'h1234_5678});
    vecs.push_back('{1'b0, 32'h0000_0020, 32'h0,         1'b1, 32'hCAFE_F00D});
    vecs.push_back('{1'b0, 32'h0000_FC20, 32'h0,         1'b1, 32'hCAFE_F00D});
    vecs.push_back('{1'b0, 32'h7FFF_0020, 32'h0,         1'b1, 32'hCAFE_F00D});
    vecs.push_back('{1'b1, 32'h0000_03FC, 32'hA5A5_A5A5, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 32'h0000_03FC, 32'h0,         1'b1, 32'hA5A5_A5A5});
    vecs.push_back('{1'b0, 32'h0000_0010, 32'h0,         1'b1, 32'hDEAD_BEEF});
`ifdef DMEM_MMIO_EN
    vecs.push_back('{1'b1, 32'hFFFF_0010, 32'h1111_2222, 1'b1, 32'h0});
    vecs.push_back('{1'b0, 32'h0000_0010, 32'h0,         1'b1, 32'hDEAD_BEEF});
    vecs.push_back('{1'b0, 32'hFFFF_000C, 32'h0,         1'b1, 32'h0});
    vecs.push_back('{1'b0, TX_ADDR,       32'h0,         1'b1, 32'h0});
`else
    vecs.push_back('{1'b1, 32'hFFFF_0010, 32'h1111_2222, 1'b1, 32'hDEAD_BEEF});
    vecs.push_back('{1'b0, 32'h0000_0010, 32'h0,         1'b1, 32'h1111_2222});
`endif
    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].w, vecs[i].addr, vecs[i].data, 1'b0);
      if (vecs[i].chk) check($sformatf("ram_vec%0d", i), rd, vecs[i].exp);
    end

`ifdef DMEM_MMIO_EN
    // ---------------- CYCLES wrap ----------------
    @(negedge clk);
    we = 1'b0; a = CYC_ADDR;
    force dut.cycles_reg = 32'hFFFF_FFFF;
    #1;
    check("cycles_forced", rd, 32'hFFFF_FFFF);
    release dut.cycles_reg;
    step(1'b0, CYC_ADDR, 32'h0, 1'b0);
    check("cycles_wrap", rd, 32'h0);

    // ---------------- push latency / hold ----------------
    step(1'b1, TX_ADDR, 32'h55, 1'b0); sb.push_back(32'h55);
    check("valid_during_push", {31'b0, out_valid}, 32'h0);
    step(1'b0, ST_ADDR, 32'h0, 1'b0);
    check("valid_after_push", {31'b0, out_valid}, 32'h1);
    check("status_one", rd, 32'h01);
    step(1'b0, 32'h0, 32'h0, 1'b0);
    check("hold_out_data", out_data, 32'h55);
    step(1'b0, 32'h0, 32'h0, 1'b1);
    step(1'b1, TX_ADDR, 32'h66, 1'b1); sb.push_back(32'h66);
    step(1'b0, ST_ADDR, 32'h0, 1'b0);
    check("push_pop_empty", rd, 32'h01);
    step(1'b0, 32'h0, 32'h0, 1'b1);

    // ---------------- overflow ----------------
    for (int i = 1; i <= 5; i++) begin
      step(1'b1, TX_ADDR, 32'(i), 1'b0);
      if (i <= 4) sb.push_back(32'(i));
    end
    step(1'b0, ST_ADDR, 32'h0, 1'b0);
    check("status_overflow", rd, 32'h34);
    step(1'b1, ST_ADDR, 32'h0, 1'b0);
    step(1'b0, ST_ADDR, 32'h0, 1'b0);
    check("status_cleared", rd, 32'h14);

    // ---------------- drain 1..4 ----------------
    repeat (4) step(1'b0, 32'h0, 32'h0, 1'b1);
    step(1'b0, ST_ADDR, 32'h0, 1'b0);
    check("drained_valid", {31'b0, out_valid}, 32'h0);
    check("drained_status", rd, 32'h08);

    // ---------------- push while full with pop ----------------
    for (int i = 0; i < 4; i++) begin
      step(1'b1, TX_ADDR, 32'hA1 + 32'(i), 1'b0);
      sb.push_back(32'hA1 + 32'(i));
    end
    step(1'b1, TX_ADDR, 32'hBAD, 1'b1);
    step(1'b0, ST_ADDR, 32'h0, 1'b0);
    check("full_push_pop", rd, 32'h23);
    step(1'b1, ST_ADDR, 32'h0, 1'b0);
    repeat (3) step(1'b0, 32'h0, 32'h0, 1'b1);
    step(1'b0, ST_ADDR, 32'h0, 1'b0);
    check("status_empty2", rd, 32'h08);

    // ---------------- simultaneous push/pop at count 2 ----------------
    step(1'b1, TX_ADDR, 32'h8, 1'b0); sb.push_back(32'h8);
    step(1'b1, TX_ADDR, 32'h9, 1'b0); sb.push_back(32'h9);
    step(1'b1, TX_ADDR, 32'h7, 1'b1); sb.push_back(32'h7);
    step(1'b0, ST_ADDR, 32'h0, 1'b0);
    check("count_stays_2", rd, 32'h02);
    repeat (2) step(1'b0, 32'h0, 32'h0, 1'b1);
    check("sb_after_34", 32'(sb.size()), 32'h0);

    // ---------------- reset with queued words ----------------
    for (int i = 0; i < 3; i++) begin
      step(1'b1, TX_ADDR, 32'h31 + 32'(i), 1'b0);
      sb.push_back(32'h31 + 32'(i));
    end
    step(1'b0, 32'h0, 32'h0, 1'b0);
    check("queued_valid", {31'b0, out_valid}, 32'h1);
    #2 reset = 1'b1;
    #1;
    check("async_rst_valid", {31'b0, out_valid}, 32'h0);
    check("async_rst_data", out_data, 32'h0);
    sb.delete();
`else
    @(negedge clk);
    reset = 1'b1;
    step(1'b1, TX_ADDR, 32'h1357_2468, 1'b1);
    check("nommio_valid", {31'b0, out_valid}, 32'h0);
    check("nommio_data", out_data, 32'h0);
    step(1'b0, 32'h0, 32'h0, 1'b1);
    check("nommio_tx_ram", rd, 32'h1357_2468);
`endif

    // Writes during reset: RAM takes them, the FIFO does not.
    step(1'b1, 32'h0000_0040, 32'h77, 1'b0);
    step(1'b1, TX_ADDR, 32'h99, 1'b0);
    @(negedge clk);
    reset = 1'b0; we = 1'b0;
    step(1'b0, 32'h0000_0040, 32'h0, 1'b0);
    check("ram_write_in_reset", rd, 32'h77);
`ifdef DMEM_MMIO_EN
    step(1'b0, ST_ADDR, 32'h0, 1'b1);
    check("status_after_rst", rd, 32'h08);
    check("valid_after_rst", {31'b0, out_valid}, 32'h0);
`endif
    check("sb_drained", 32'(sb.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
